// File: rtl/mrv32_id_stage.sv
// MRV32 instruction-decode stage: decodes RV32I(+M) into a control bundle,
// with load-use hazard hold, flush and an optional registered-ready skid buffer.
package mrv32_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_EQ   = 4'd1,
    BR_NE   = 4'd2,
    BR_LT   = 4'd3,
    BR_GE   = 4'd4,
    BR_LTU  = 4'd5,
    BR_GEU  = 4'd6,
    BR_JAL  = 4'd7,
    BR_JALR = 4'd8
  } br_sel_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_sel_e;

  // Access width as byte-lane mask; used for both loads and stores.
  localparam logic [3:0] WSTRB_NONE = 4'b0000;
  localparam logic [3:0] WSTRB_B    = 4'b0001;
  localparam logic [3:0] WSTRB_H    = 4'b0011;
  localparam logic [3:0] WSTRB_W    = 4'b1111;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    alu_op_e     aluop;
    logic        alusrc;
    logic        mem_ren;
    logic        mem_wen;
    logic [3:0]  mem_wstrb;
    logic        load_unsigned;
    logic        reg_wen;
    logic        is_lui;
    logic        is_auipc;
    logic        is_jalr;
    br_sel_e     br_sel;
    logic [31:0] imm;
    logic        is_muldiv;
    logic [2:0]  muldiv_op;
    logic        illegal;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    ctrl_t       ctrl;
    logic        uses_rs1;
    logic        uses_rs2;
  } entry_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_sel_e sel);
    logic [31:0] imm;
    case (sel)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

  function automatic alu_op_e alu_base(input logic [2:0] f3);
    alu_op_e op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

module mrv32_id_stage
  import mrv32_pkg::*;
#(
  parameter bit EN_M      = 1'b0,
  parameter bit REG_READY = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output ctrl_t       out_ctrl
);

  function automatic entry_t decode(input logic [31:0] instr, input logic [31:0] pc);
    entry_t      e;
    imm_sel_e    isel;
    logic        writes;
    logic [6:0]  f7;
    logic [2:0]  f3;
    e            = '0;
    isel         = IMM_NONE;
    writes       = 1'b0;
    f7           = instr[31:25];
    f3           = instr[14:12];
    e.pc         = pc;
    e.ctrl.rs1   = instr[19:15];
    e.ctrl.rs2   = instr[24:20];
    e.ctrl.rd    = instr[11:7];
    case (instr[6:0])
      7'b0110111: begin
        e.ctrl.is_lui = 1'b1; e.ctrl.alusrc = 1'b1; isel = IMM_U; writes = 1'b1;
      end
      7'b0010111: begin
        e.ctrl.is_auipc = 1'b1; e.ctrl.alusrc = 1'b1; isel = IMM_U; writes = 1'b1;
      end
      7'b1101111: begin
        e.ctrl.br_sel = BR_JAL; isel = IMM_J; writes = 1'b1;
      end
      7'b1100111: begin
        e.ctrl.is_jalr = 1'b1; e.ctrl.br_sel = BR_JALR; e.ctrl.alusrc = 1'b1;
        isel = IMM_I; writes = 1'b1; e.uses_rs1 = 1'b1;
        e.ctrl.illegal = (f3 != 3'b000);
      end
      7'b1100011: begin
        isel = IMM_B; e.uses_rs1 = 1'b1; e.uses_rs2 = 1'b1;
        case (f3)
          3'b000:  e.ctrl.br_sel = BR_EQ;
          3'b001:  e.ctrl.br_sel = BR_NE;
          3'b100:  e.ctrl.br_sel = BR_LT;
          3'b101:  e.ctrl.br_sel = BR_GE;
          3'b110:  e.ctrl.br_sel = BR_LTU;
          3'b111:  e.ctrl.br_sel = BR_GEU;
          default: e.ctrl.illegal = 1'b1;
        endcase
      end
      7'b0000011: begin
        e.ctrl.mem_ren = 1'b1; e.ctrl.alusrc = 1'b1; isel = IMM_I; writes = 1'b1;
        e.uses_rs1 = 1'b1; e.ctrl.load_unsigned = f3[2];
        case (f3)
          3'b000, 3'b100: e.ctrl.mem_wstrb = WSTRB_B;
          3'b001, 3'b101: e.ctrl.mem_wstrb = WSTRB_H;
          3'b010:         e.ctrl.mem_wstrb = WSTRB_W;
          default:        e.ctrl.illegal = 1'b1;
        endcase
      end
      7'b0100011: begin
        e.ctrl.mem_wen = 1'b1; e.ctrl.alusrc = 1'b1; isel = IMM_S;
        e.uses_rs1 = 1'b1; e.uses_rs2 = 1'b1;
        case (f3)
          3'b000:  e.ctrl.mem_wstrb = WSTRB_B;
          3'b001:  e.ctrl.mem_wstrb = WSTRB_H;
          3'b010:  e.ctrl.mem_wstrb = WSTRB_W;
          default: e.ctrl.illegal = 1'b1;
        endcase
      end
      7'b0010011: begin
        e.ctrl.alusrc = 1'b1; isel = IMM_I; writes = 1'b1; e.uses_rs1 = 1'b1;
        e.ctrl.aluop = alu_base(f3);
        // Shift-immediates reuse funct7 as an opcode extension; anything else is reserved.
        if (f3 == 3'b001 && f7 != 7'b0000000) e.ctrl.illegal = 1'b1;
        if (f3 == 3'b101) begin
          if (f7 == 7'b0100000)      e.ctrl.aluop = ALU_SRA;
          else if (f7 != 7'b0000000) e.ctrl.illegal = 1'b1;
        end
      end
      7'b0110011: begin
        writes = 1'b1; e.uses_rs1 = 1'b1; e.uses_rs2 = 1'b1;
        case (f7)
          7'b0000000: e.ctrl.aluop = alu_base(f3);
          7'b0100000: begin
            if (f3 == 3'b000)      e.ctrl.aluop = ALU_SUB;
            else if (f3 == 3'b101) e.ctrl.aluop = ALU_SRA;
            else                   e.ctrl.illegal = 1'b1;
          end
          7'b0000001: begin
            if (EN_M) begin
              e.ctrl.is_muldiv = 1'b1; e.ctrl.muldiv_op = f3;
            end else begin
              e.ctrl.illegal = 1'b1;
            end
          end
          default: e.ctrl.illegal = 1'b1;
        endcase
      end
      7'b0001111: ;
      default: e.ctrl.illegal = 1'b1;
    endcase
    e.ctrl.imm     = gen_imm(instr, isel);
    e.ctrl.reg_wen = writes && (instr[11:7] != 5'd0);
    if (e.ctrl.illegal) begin
      e.ctrl.reg_wen   = 1'b0;
      e.ctrl.mem_ren   = 1'b0;
      e.ctrl.mem_wen   = 1'b0;
      e.ctrl.is_muldiv = 1'b0;
      e.ctrl.br_sel    = BR_NONE;
    end
    return e;
  endfunction

  entry_t in_dec;
  entry_t held_q, held_d;
  entry_t skid_q, skid_d;
  logic   held_valid_q, held_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   rdy_q;
  logic   hazard;
  logic   in_fire;
  logic   out_fire;

  always_comb in_dec = decode(in_instr, in_pc);

  assign hazard = ex_is_load && (ex_rd != 5'd0) &&
                  ((held_q.uses_rs1 && held_q.ctrl.rs1 == ex_rd) ||
                   (held_q.uses_rs2 && held_q.ctrl.rs2 == ex_rd));

  assign out_valid = held_valid_q && !hazard;
  assign out_pc    = held_q.pc;
  assign out_ctrl  = held_q.ctrl;
  assign in_ready  = REG_READY ? rdy_q
                               : (rdy_q && (!held_valid_q || (out_ready && !hazard)));
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    held_d       = held_q;
    held_valid_d = held_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      held_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!held_valid_q || out_fire) begin
      if (skid_valid_q) begin
        held_d       = skid_q;
        held_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        held_d       = in_dec;
        held_valid_d = 1'b1;
      end else begin
        held_valid_d = 1'b0;
      end
    end else if (in_fire && REG_READY) begin
      skid_d       = in_dec;
      skid_valid_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q       <= '0;
      held_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      rdy_q        <= 1'b0;
    end else begin
      held_q       <= held_d;
      held_valid_q <= held_valid_d;
      skid_valid_q <= skid_valid_d;
      rdy_q        <= REG_READY ? !skid_valid_d : 1'b1;
    end
  end

  // NOTE: skid payload needs no reset; skid_valid_q guards every use of it.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

endmodule

// File: doc/mrv32_id_stage.md
MRV32_ID_STAGE -- requirements
Module: mrv32_id_stage

Interface
REQ-001 SHALL have parameter EN_M, default 0; 1 decodes RV32M (MUL/DIV/REM), 0 flags them illegal.
REQ-002 SHALL have parameter REG_READY, default 1; 1 gives a 2-entry skid buffer with registered in_ready, 0 gives a single pipeline register.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk and rst_n.
REQ-004 Ports SHALL be, one per line:
- clk  in  1  rising-edge clock
- rst_n  in  1  async reset, active low
- in_valid  in  1  fetch holds an instruction
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  32  instruction address
- flush  in  1  squash all held instructions
- ex_rd  in  5  destination register of the EX-stage instruction
- ex_is_load  in  1  EX-stage instruction is a load
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  EX accepts the bundle
- out_pc  out  32  PC of the bundle
- out_ctrl  out  ctrl_t  rs1, rs2, rd, aluop, alusrc, mem_ren, mem_wen, mem_wstrb, load_unsigned, reg_wen, is_lui, is_auipc, is_jalr, br_sel, imm, is_muldiv, muldiv_op[2:0], illegal

Function
REQ-005 An input transfer SHALL occur on in_valid && in_ready; an output transfer on out_valid && out_ready.
REQ-006 Latency SHALL be 1 cycle from input transfer to out_valid, absent hazard or backpressure.
REQ-007 Decode SHALL be registered at input transfer; out_pc and out_ctrl SHALL stay stable while out_valid && !out_ready.
REQ-008 Decode SHALL implement RV32I LUI, AUIPC, JAL, JALR, B-type, loads, stores, OP-IMM and OP, using the mrv32_pkg ALU, WSTRB, BR and IMM encodings.
REQ-009 reg_wen SHALL be 0 when rd==0 or when the instruction does not write rd.
REQ-010 FENCE (opcode 0001111) SHALL decode as a legal NOP with all enables 0.
REQ-011 illegal SHALL be 1 for:
- unknown opcode
- B-type funct3 010 or 011
- load funct3 011, 110 or 111
- store funct3 >= 011
- SLLI with funct7 != 0
- SRLI/SRAI or OP with an unlisted funct7
- JALR funct3 != 0
- OP with funct7 0000001 when EN_M=0
REQ-012 When illegal=1, reg_wen, mem_ren, mem_wen and is_muldiv SHALL be 0 and br_sel SHALL be BR_NONE; the bundle SHALL still be delivered with out_valid=1.
REQ-013 When EN_M=1, OP with funct7 0000001 SHALL set is_muldiv=1, set muldiv_op=funct3 and apply the normal reg_wen rule.
REQ-014 uses_rs1 SHALL be 1 for JALR, B-type, load, store, OP-IMM and OP; uses_rs2 SHALL be 1 for B-type, store and OP.
REQ-015 hazard SHALL equal ex_is_load && ex_rd!=0 && ((uses_rs1 && rs1==ex_rd) || (uses_rs2 && rs2==ex_rd)), evaluated on the held bundle.
REQ-016 While hazard=1, out_valid SHALL be 0 and the bundle SHALL be held unchanged.
REQ-017 REG_READY=0: in_ready SHALL equal !held_valid || (out_ready && !hazard).
REQ-018 REG_READY=1: in_ready SHALL be a flop equal to "skid entry empty".
- An input accepted while the output stalls SHALL go to the skid entry.
- The skid entry SHALL promote to the output register on the next output transfer.
- Full throughput of 1 instruction per cycle SHALL be sustained while out_ready=1.
REQ-019 flush SHALL be synchronous and SHALL clear the held and skid valid bits at the next edge.
- An input presented in the flush cycle SHALL be discarded.
- out_valid SHALL be 0 in the cycle after flush.
- flush SHALL have priority over every simultaneous transfer.
REQ-020 Ordering SHALL be strictly in order; no instruction SHALL be duplicated or dropped except by flush.

Reset
REQ-021 While rst_n=0, the stage SHALL immediately force out_valid=0, skid empty, out_pc=0 and out_ctrl all-zero.
REQ-022 While rst_n=0, in_ready SHALL be 0; it SHALL be 1 from the first edge after rst_n deassertion.
REQ-023 Reset asserted mid-stall SHALL discard held instructions; none SHALL appear after release.

Verification
REQ-024 The bench SHALL cover the following scenarios:
- ADDI x5,x0,7 (0x00700293) with out_ready=1 -> the next cycle gives out_valid=1, aluop=ALU_ADD, alusrc=1, imm=7, reg_wen=1.
- LW x6,0(x1) accepted, then ADD x7,x6,x2 held with ex_rd=6, ex_is_load=1 -> out_valid=0 for 1 cycle; after ex_is_load=0 the ADD is delivered once.
- Instruction 0x0000A063 (B-type funct3 010) -> illegal=1, br_sel=BR_NONE, out_valid=1.
- EN_M=1, MUL x3,x1,x2 -> is_muldiv=1, muldiv_op=0; EN_M=0, same word -> illegal=1, reg_wen=0.
- REG_READY=1, a 4-instruction burst with out_ready=0 for 2 cycles -> in_ready falls after 2 accepts; all 4 emerge in order with no loss.
- flush asserted while both entries are full and in_valid=1 -> out_valid=0 next cycle; no old instruction emerges.
